// File: rtl/rgb_pwm_gen.sv
`default_nettype none
// ============================================================================
//  Module   : rgb_pwm_gen
//  Brief    : Three-channel 8-bit PWM for an RGB LED. Duty shadows reload only
//             at period boundaries so duty updates never glitch a period.
//  Revision : 1.0  initial release
// ============================================================================
module rgb_pwm_gen #(
  parameter int PRESCALE   = 1,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clk_div,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] R_time_in,
  input  logic [7:0] G_time_in,
  input  logic [7:0] B_time_in,
  output logic       pwm_r,
  output logic       pwm_g,
  output logic       pwm_b,
  output logic       period_start
);

  localparam int                 c_PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(PRESCALE - 1);
  localparam logic [c_PRE_W-1:0] c_PRE_ONE = c_PRE_W'(1);
  localparam logic               c_IDLE    = ACTIVE_LOW;

  logic [c_PRE_W-1:0] r_pre_cnt;
  logic [7:0]         r_pwm_cnt;
  logic [7:0]         r_sh_r;
  logic [7:0]         r_sh_g;
  logic [7:0]         r_sh_b;

  logic w_tick;
  logic w_load;
  logic w_on_r;
  logic w_on_g;
  logic w_on_b;

  assign w_tick = (r_pre_cnt == c_PRE_MAX);
  assign w_load = w_tick && (r_pwm_cnt == 8'hFF);

  // 0xFF is special-cased so full duty has no single-count dark gap
  assign w_on_r = (r_sh_r == 8'hFF) | (r_pwm_cnt < r_sh_r);
  assign w_on_g = (r_sh_g == 8'hFF) | (r_pwm_cnt < r_sh_g);
  assign w_on_b = (r_sh_b == 8'hFF) | (r_pwm_cnt < r_sh_b);

  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      r_pre_cnt    <= '0;
      r_pwm_cnt    <= 8'h00;
      r_sh_r       <= 8'h00;
      r_sh_g       <= 8'h00;
      r_sh_b       <= 8'h00;
      period_start <= 1'b0;
    end else if (!en) begin
      // Shadows track the inputs while idle so the first enabled period uses fresh duties
      r_pre_cnt    <= '0;
      r_pwm_cnt    <= 8'h00;
      r_sh_r       <= R_time_in;
      r_sh_g       <= G_time_in;
      r_sh_b       <= B_time_in;
      period_start <= 1'b0;
    end else begin
      r_pre_cnt    <= w_tick ? '0 : (r_pre_cnt + c_PRE_ONE);
      period_start <= w_load;
      if (w_tick) begin
        r_pwm_cnt <= r_pwm_cnt + 8'd1;
      end
      if (w_load) begin
        r_sh_r <= R_time_in;
        r_sh_g <= G_time_in;
        r_sh_b <= B_time_in;
      end
    end
  end

  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      pwm_r <= c_IDLE;
      pwm_g <= c_IDLE;
      pwm_b <= c_IDLE;
    end else begin
      pwm_r <= en ? (w_on_r ^ c_IDLE) : c_IDLE;
      pwm_g <= en ? (w_on_g ^ c_IDLE) : c_IDLE;
      pwm_b <= en ? (w_on_b ^ c_IDLE) : c_IDLE;
    end
  end

endmodule
`default_nettype wire
